// File: rtl/fetch_inst_buffer.sv
// ============================================================================
// Module   : fetch_inst_buffer
// Function : Circular instruction queue between 5-wide fetch and 3-wide decode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_inst_buffer #(
  parameter int size  = 32,
  parameter int DEPTH = 16,
  parameter int GH_W  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush_i,
  input  logic [4:0]                    fetch_valid_i,
  output logic                          fetch_ready_o,
  input  logic [4:0][size-1:0]          instr_i,
  input  logic [4:0][size-1:0]          pc_i,
  input  logic [4:0][size-1:0]          imm_i,
  input  logic [4:0][size-1:0]          pred_pc_i,
  input  logic [4:0]                    pred_taken_i,
  input  logic [4:0][GH_W-1:0]          ghist_i,
  input  logic [2:0]                    ras_tos_i,
  output logic [2:0]                    dec_valid_o,
  input  logic                          dec_ready_i,
  output logic [2:0][size-1:0]          instr_o,
  output logic [2:0][size-1:0]          pc_o,
  output logic [2:0][size-1:0]          imm_o,
  output logic [2:0][size-1:0]          pred_pc_o,
  output logic [2:0]                    pred_taken_o,
  output logic [2:0][GH_W-1:0]          ghist_o,
  output logic [2:0][2:0]               ras_tos_o,
  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] FETCH_W_C  = CW'(5);

  typedef struct packed {
    logic [size-1:0] instr;
    logic [size-1:0] pc;
    logic [size-1:0] imm;
    logic [size-1:0] pred_pc;
    logic            taken;
    logic [GH_W-1:0] ghist;
    logic [2:0]      ras;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic [2:0]      n_enq;
  logic [1:0]      n_deq;
  logic            run;
  logic            fetch_ready;

  // Readiness depends only on registered occupancy, never on this cycle's traffic.
  assign fetch_ready   = (DEPTH_C - count_q) >= FETCH_W_C;
  assign fetch_ready_o = fetch_ready;
  assign count_o       = count_q;

  always_comb begin
    n_enq = 3'd0;
    run   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (run && fetch_valid_i[k]) begin
        n_enq = n_enq + 3'd1;
      end else begin
        run = 1'b0;
      end
    end
    if (!fetch_ready || flush_i) begin
      n_enq = 3'd0;
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      dec_valid_o[k]  = count_q > CW'(k);
      instr_o[k]      = mem_q[head_q + PW'(k)].instr;
      pc_o[k]         = mem_q[head_q + PW'(k)].pc;
      imm_o[k]        = mem_q[head_q + PW'(k)].imm;
      pred_pc_o[k]    = mem_q[head_q + PW'(k)].pred_pc;
      pred_taken_o[k] = mem_q[head_q + PW'(k)].taken;
      ghist_o[k]      = mem_q[head_q + PW'(k)].ghist;
      ras_tos_o[k]    = mem_q[head_q + PW'(k)].ras;
    end
  end

  always_comb begin
    n_deq = 2'd0;
    if (dec_ready_i && !flush_i) begin
      n_deq = (count_q >= CW'(3)) ? 2'd3 : count_q[1:0];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    for (int k = 0; k < 5; k++) begin
      if (3'(k) < n_enq) begin
        mem_d[tail_q + PW'(k)] = '{instr:   instr_i[k],
                                   pc:      pc_i[k],
                                   imm:     imm_i[k],
                                   pred_pc: pred_pc_i[k],
                                   taken:   pred_taken_i[k],
                                   ghist:   ghist_i[k],
                                   ras:     ras_tos_i};
      end
    end
  end

  always_comb begin
    head_d  = head_q + PW'(n_deq);
    tail_d  = tail_q + PW'(n_enq);
    count_d = count_q + CW'(n_enq) - CW'(n_deq);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Storage holds no valid state on its own, so it is left unreset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_inst_buffer.sv
// ============================================================================
// Module   : tb_fetch_inst_buffer
// Function : Directed self-checking bench for fetch_inst_buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_inst_buffer;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush_i;
  logic [4:0]        fetch_valid_i;
  logic              fetch_ready_o;
  logic [4:0][31:0]  instr_i, pc_i, imm_i, pred_pc_i;
  logic [4:0]        pred_taken_i;
  logic [4:0][7:0]   ghist_i;
  logic [2:0]        ras_tos_i;
  logic [2:0]        dec_valid_o;
  logic              dec_ready_i;
  logic [2:0][31:0]  instr_o, pc_o, imm_o, pred_pc_o;
  logic [2:0]        pred_taken_o;
  logic [2:0][7:0]   ghist_o;
  logic [2:0][2:0]   ras_tos_o;
  logic [4:0]        count_o;

  int n_checks = 0;
  int n_errors = 0;

  fetch_inst_buffer #(.size(32), .DEPTH(16), .GH_W(8)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .imm_i(imm_i), .pred_pc_i(pred_pc_i),
    .pred_taken_i(pred_taken_i), .ghist_i(ghist_i), .ras_tos_i(ras_tos_i),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .instr_o(instr_o), .pc_o(pc_o), .imm_o(imm_o), .pred_pc_o(pred_pc_o),
    .pred_taken_o(pred_taken_o), .ghist_o(ghist_o), .ras_tos_o(ras_tos_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] v, input logic [31:0] base);
    fetch_valid_i = v;
    for (int k = 0; k < 5; k++) begin
      pc_i[k]      = base + 32'(4 * k);
      instr_i[k]   = ~(base + 32'(4 * k));
      imm_i[k]     = base + 32'(4 * k) + 32'd1;
      pred_pc_i[k] = base + 32'(4 * k) + 32'd2;
      ghist_i[k]   = 8'(k + 1);
    end
    pred_taken_i = 5'b10101;
    ras_tos_i    = base[6:4] ^ 3'b011;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(5'b00000, 32'h0);
    dec_ready_i = 1'b0;
    flush_i     = 1'b0;
    step();
    reset = 1'b0;
  endtask

  int          m_count;
  logic [31:0] m_out_pc;
  logic [31:0] m_in_pc;
  int          m_enq, m_deq;

  initial begin
    reset = 1'b1; flush_i = 1'b0; dec_ready_i = 1'b0;
    drive(5'b00000, 32'h0);
    step();
    step();
    reset = 1'b0;
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_valid", 32'(dec_valid_o), 32'd0);
    check("rst_ready", 32'(fetch_ready_o), 32'd1);

    // Full 5-wide group, no dequeue
    drive(5'b11111, 32'h0);
    step();
    drive(5'b00000, 32'h0);
    check("t1_count", 32'(count_o), 32'd5);
    check("t1_valid", 32'(dec_valid_o), 32'h7);
    check("t1_pc0", pc_o[0], 32'h00);
    check("t1_pc1", pc_o[1], 32'h04);
    check("t1_pc2", pc_o[2], 32'h08);
    check("t1_instr2", instr_o[2], ~32'h08);
    check("t1_imm1", imm_o[1], 32'h05);
    check("t1_predpc0", pred_pc_o[0], 32'h02);
    check("t1_taken", 32'(pred_taken_o), 32'b101);
    check("t1_ghist1", 32'(ghist_o[1]), 32'd2);
    check("t1_ras2", 32'(ras_tos_o[2]), 32'd3);

    // Partial groups: only the leading run of valids is taken
    do_reset();
    drive(5'b00111, 32'h100);
    step();
    check("t2_count_a", 32'(count_o), 32'd3);
    drive(5'b10011, 32'h200);
    step();
    check("t2_count_b", 32'(count_o), 32'd5);
    drive(5'b00000, 32'h0);
    dec_ready_i = 1'b1;
    check("t2_pc0", pc_o[0], 32'h100);
    check("t2_pc2", pc_o[2], 32'h108);
    step();
    check("t2_count_c", 32'(count_o), 32'd2);
    check("t2_valid_c", 32'(dec_valid_o), 32'b011);
    check("t2_pc0_c", pc_o[0], 32'h200);
    check("t2_pc1_c", pc_o[1], 32'h204);
    step();
    check("t2_count_d", 32'(count_o), 32'd0);
    check("t2_valid_d", 32'(dec_valid_o), 32'b000);
    dec_ready_i = 1'b0;

    // Back-pressure at count 12
    do_reset();
    drive(5'b11111, 32'h300); step();
    drive(5'b11111, 32'h314); step();
    drive(5'b00011, 32'h328); step();
    check("t3_count12", 32'(count_o), 32'd12);
    check("t3_ready0", 32'(fetch_ready_o), 32'd0);
    drive(5'b11111, 32'h400);
    step();
    check("t3_nowrite", 32'(count_o), 32'd12);
    check("t3_pc0", pc_o[0], 32'h300);
    dec_ready_i = 1'b1;
    step();
    dec_ready_i = 1'b0;
    check("t3_count9", 32'(count_o), 32'd9);
    check("t3_ready1", 32'(fetch_ready_o), 32'd1);
    check("t3_pc0_b", pc_o[0], 32'h30C);

    // Bring head and tail to 14, then stream across the 15->0 boundary
    do_reset();
    drive(5'b11111, 32'h0); step();
    drive(5'b11111, 32'h0); step();
    drive(5'b01111, 32'h0); step();
    drive(5'b00000, 32'h0);
    dec_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("t4_empty", 32'(count_o), 32'd0);
    m_count  = 0;
    m_out_pc = 32'h1000;
    m_in_pc  = 32'h1000;
    for (int c = 0; c < 10; c++) begin
      drive(5'b11111, m_in_pc);
      m_enq = (16 - m_count >= 5) ? 5 : 0;
      m_deq = (m_count >= 3) ? 3 : m_count;
      check("t4_ready", 32'(fetch_ready_o), 32'(m_enq == 5));
      for (int k = 0; k < 3; k++) begin
        if (k < m_deq) check("t4_pc", pc_o[k], m_out_pc + 32'(4 * k));
      end
      step();
      m_count  = m_count + m_enq - m_deq;
      m_in_pc  = m_in_pc + 32'(4 * m_enq);
      m_out_pc = m_out_pc + 32'(4 * m_deq);
      check("t4_count", 32'(count_o), 32'(m_count));
    end

    // Flush beats enqueue and dequeue
    do_reset();
    drive(5'b11111, 32'h700); step();
    drive(5'b00011, 32'h714); step();
    check("t5_count7", 32'(count_o), 32'd7);
    flush_i = 1'b1;
    dec_ready_i = 1'b1;
    drive(5'b11111, 32'h740);
    check("t5_valid_during", 32'(dec_valid_o), 32'h7);
    step();
    flush_i = 1'b0;
    dec_ready_i = 1'b0;
    check("t5_count0", 32'(count_o), 32'd0);
    check("t5_valid0", 32'(dec_valid_o), 32'd0);
    check("t5_ready", 32'(fetch_ready_o), 32'd1);
    drive(5'b11111, 32'h800);
    step();
    drive(5'b00000, 32'h0);
    check("t5_after_pc0", pc_o[0], 32'h800);
    check("t5_after_count", 32'(count_o), 32'd5);

    // Dequeue two while enqueueing one
    do_reset();
    drive(5'b00011, 32'h900); step();
    dec_ready_i = 1'b1;
    drive(5'b00001, 32'hA00);
    check("t6_valid011", 32'(dec_valid_o), 32'b011);
    step();
    dec_ready_i = 1'b0;
    drive(5'b00000, 32'h0);
    check("t6_count1", 32'(count_o), 32'd1);
    check("t6_pc0", pc_o[0], 32'hA00);
    check("t6_valid001", 32'(dec_valid_o), 32'b001);

    // Reset mid-operation clears occupancy like a flush
    drive(5'b11111, 32'hB00); step();
    drive(5'b00000, 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t7_count", 32'(count_o), 32'd0);
    check("t7_valid", 32'(dec_valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
